// File: rtl/i2s_rx.sv
// I2S receiver: recovers 16-bit left/right words from an asynchronous bit stream
// and presents each complete pair as a registered sample with lock tracking.
module i2s_rx #(
  parameter int CHANNEL_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk_74a,
  input  logic                     reset,
  input  logic                     i2s_sclk,
  input  logic                     i2s_lrck,
  input  logic                     i2s_dat,
  output logic [CHANNEL_WIDTH-1:0] audio_l,
  output logic [CHANNEL_WIDTH-1:0] audio_r,
  output logic                     sample_valid,
  output logic                     locked,
  output logic                     frame_error
);

  localparam int                IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [4:0]        FULL_CNT = 5'd16;
  localparam logic [4:0]        LAST_CNT = 5'd15;

  typedef enum logic [1:0] {HUNT, RX_LEFT, RX_RIGHT} state_t;

  state_t                   state;
  logic [2:0]               sync_q1;
  logic [2:0]               sync_q2;
  logic                     sclk_prev;
  logic                     lrck_prev;
  logic [4:0]               bit_cnt;
  logic [15:0]              shreg;
  logic [CHANNEL_WIDTH-1:0] held_l;
  logic [IDLE_W-1:0]        idle_cnt;

  logic        sclk_s;
  logic        lrck_s;
  logic        dat_s;
  logic        sclk_rise;
  logic        delay_bit;
  logic [15:0] word;
  logic        unused_bits;

  // Same two-flop synchronizer for all three pins, kept as one bundle.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_74a) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {i2s_sclk, i2s_lrck, i2s_dat};
      sync_q2 <= sync_q1;
    end
  end

  assign sclk_s      = sync_q2[2];
  assign lrck_s      = sync_q2[1];
  assign dat_s       = sync_q2[0];
  assign sclk_rise   = sclk_s & ~sclk_prev;
  assign delay_bit   = sclk_rise & (lrck_s != lrck_prev);
  assign word        = {shreg[14:0], dat_s};
  assign unused_bits = ^{shreg[15], word};

  always_ff @(posedge clk_74a) begin
    if (reset) begin
      state        <= HUNT;
      sclk_prev    <= 1'b0;
      lrck_prev    <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
      held_l       <= '0;
      idle_cnt     <= '0;
      audio_l      <= '0;
      audio_r      <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      sclk_prev    <= sclk_s;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;

      if (sclk_rise) begin
        idle_cnt  <= '0;
        lrck_prev <= lrck_s;
        if (delay_bit) begin
          bit_cnt <= '0;
          shreg   <= '0;
          case (state)
            RX_LEFT, RX_RIGHT: begin
              if (bit_cnt == FULL_CNT) begin
                state <= lrck_s ? RX_RIGHT : RX_LEFT;
              end else begin
                // Short word: drop everything; a new left word may start right here.
                frame_error <= 1'b1;
                locked      <= 1'b0;
                held_l      <= '0;
                state       <= lrck_s ? HUNT : RX_LEFT;
              end
            end
            default: begin
              if (!lrck_s) state <= RX_LEFT;
            end
          endcase
        end else if (bit_cnt != FULL_CNT) begin
          shreg   <= word;
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == LAST_CNT) begin
            case (state)
              RX_LEFT:  held_l <= word[15 -: CHANNEL_WIDTH];
              RX_RIGHT: begin
                audio_l      <= held_l;
                audio_r      <= word[15 -: CHANNEL_WIDTH];
                sample_valid <= 1'b1;
                locked       <= 1'b1;
              end
              default: ;
            endcase
          end
        end
      end else begin
        if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
        // Lock drops on the cycle the idle count reaches the limit.
        if (idle_cnt == IDLE_MAX - 1'b1) begin
          locked <= 1'b0;
          state  <= HUNT;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: random I2S words checked against a word-level
// model of which pairs must appear, when, and where framing errors occur.
module tb_i2s_rx;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          due;
  } exp_t;

  logic        clk_74a = 1'b0;
  logic        reset = 1'b1;
  logic        i2s_sclk = 1'b0;
  logic        i2s_lrck = 1'b0;
  logic        i2s_dat = 1'b0;
  logic [15:0] audio_l, audio_r;
  logic        sample_valid, locked, frame_error;
  logic [14:0] audio_l15, audio_r15;
  logic        sample_valid15, locked15, frame_error15;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Word-level reference state
  bit          in_chain = 1'b0;
  bit          exp_locked = 1'b0;
  int          cur_bits = 16;
  logic [15:0] held = '0;
  logic [15:0] exp_l = '0;
  logic [15:0] exp_r = '0;
  int          exp_ferr = 0;
  int          ferr_seen = 0;
  int          ferr15_seen = 0;
  int          last_rise = 0;
  int          fall;
  int          fe0;
  logic [15:0] r_val;
  int          r_nbits, r_slots;

  always #5 clk_74a = ~clk_74a;
  always @(posedge clk_74a) cyc <= cyc + 1;

  i2s_rx dut (
    .clk_74a(clk_74a), .reset(reset), .i2s_sclk(i2s_sclk), .i2s_lrck(i2s_lrck),
    .i2s_dat(i2s_dat), .audio_l(audio_l), .audio_r(audio_r),
    .sample_valid(sample_valid), .locked(locked), .frame_error(frame_error)
  );

  i2s_rx #(.CHANNEL_WIDTH(15)) dut15 (
    .clk_74a(clk_74a), .reset(reset), .i2s_sclk(i2s_sclk), .i2s_lrck(i2s_lrck),
    .i2s_dat(i2s_dat), .audio_l(audio_l15), .audio_r(audio_r15),
    .sample_valid(sample_valid15), .locked(locked15), .frame_error(frame_error15)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  always @(negedge clk_74a) begin
    if (sample_valid || frame_error)
      check("valid_error_exclusive", 32'(sample_valid & frame_error), 0);
    if (frame_error) ferr_seen++;
    if (frame_error15) ferr15_seen++;
    if (sample_valid) begin
      check("valid_expected", 32'(exp_q.size() != 0), 1);
      check("valid15", 32'(sample_valid15), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("audio_l", audio_l, mon_e.l);
        check("audio_r", audio_r, mon_e.r);
        check("audio_l15", audio_l15, mon_e.l[15:1]);
        check("audio_r15", audio_r15, mon_e.r[15:1]);
        check("valid_latency", cyc, mon_e.due);
      end
    end
  end

  // One SCLK period of 8 clk_74a cycles; data and LRCK change with the falling edge.
  task automatic sclk_bit(input logic lr, input logic d);
    @(negedge clk_74a);
    i2s_sclk = 1'b0;
    i2s_lrck = lr;
    i2s_dat  = d;
    repeat (4) @(negedge clk_74a);
    i2s_sclk  = 1'b1;
    last_rise = cyc;
    repeat (3) @(negedge clk_74a);
  endtask

  // A word is tracked once it starts with a left word; a tracked word shorter
  // than 16 bits is an error when the next word begins.
  task automatic model_word_start(input logic lr, input int nbits);
    if (in_chain && cur_bits < 16) begin
      exp_ferr++;
      exp_locked = 1'b0;
      in_chain   = (lr == 1'b0);
    end else begin
      in_chain = in_chain || (lr == 1'b0);
    end
    cur_bits = nbits;
  endtask

  task automatic model_word_full(input logic lr, input logic [15:0] val, input int rise);
    exp_t e;
    if (in_chain) begin
      if (lr == 1'b0) begin
        held = val;
      end else begin
        e.l = held;
        e.r = val;
        e.due = rise + 3;
        exp_q.push_back(e);
        exp_l = held;
        exp_r = val;
        exp_locked = 1'b1;
      end
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk_74a);
    i2s_sclk = 1'b0;
    reset    = 1'b1;
    @(negedge clk_74a);
    reset      = 1'b0;
    in_chain   = 1'b0;
    exp_locked = 1'b0;
    exp_l      = '0;
    exp_r      = '0;
    check("rst_mid_audio_l", audio_l, 0);
    check("rst_mid_audio_r", audio_r, 0);
    check("rst_mid_locked", 32'(locked), 0);
  endtask

  task automatic send_word(input logic lr, input logic [15:0] val, input int nbits,
                           input int slots, input int rst_at);
    for (int i = 0; i < slots; i++) begin
      logic d;
      if (i == 0) model_word_start(lr, nbits);
      if (i == 1) begin
        @(negedge clk_74a);
        check("frame_error_count", ferr_seen, exp_ferr);
        check("frame_error15_count", ferr15_seen, exp_ferr);
        check("locked", 32'(locked), 32'(exp_locked));
        check("locked15", 32'(locked15), 32'(exp_locked));
        check("audio_l_hold", audio_l, exp_l);
        check("audio_r_hold", audio_r, exp_r);
        check("audio_l15_hold", audio_l15, exp_l[15:1]);
      end
      if (i == rst_at) reset_pulse();
      d = (i >= 1 && i <= nbits) ? val[16-i] : 1'($urandom_range(0, 1));
      sclk_bit(lr, d);
      if (i == 16 && nbits == 16) model_word_full(lr, val, last_rise);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_word(1'b0, l, 16, 32, -1);
    send_word(1'b1, r, 16, 32, -1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    repeat (5) @(negedge clk_74a);
    check("rst_audio_l", audio_l, 0);
    check("rst_audio_r", audio_r, 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_frame_error", 32'(frame_error), 0);
    reset = 1'b0;

    // Stream starts mid-pair on a right word, which must be ignored.
    send_word(1'b1, 16'h5555, 16, 32, -1);
    repeat (3) send_frame(16'h1234, 16'hABCD);
    check("locked_std", 32'(locked), 1);
    check("std_audio_l", audio_l, 16'h1234);
    check("std_audio_r", audio_r, 16'hABCD);

    send_frame(16'hFFFE, 16'h8001);
    check("cw15_audio_l", audio_l15, 15'h7FFF);
    check("cw15_audio_r", audio_r15, 15'h4000);

    // Left word cut short after 10 bits.
    fe0 = ferr_seen;
    send_word(1'b0, 16'h0F0F, 10, 11, -1);
    send_word(1'b1, 16'h3C3C, 16, 32, -1);
    check("short_word_one_error", ferr_seen - fe0, 1);
    check("short_word_unlocked", 32'(locked), 0);
    repeat (2) send_frame(16'h1234, 16'hABCD);

    for (int w = 0; w < 40; w++) begin
      r_val   = 16'($urandom);
      r_nbits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : 16;
      r_slots = (r_nbits < 16) ? r_nbits + 1 : int'($urandom_range(17, 32));
      send_word(1'(w % 2), r_val, r_nbits, r_slots, -1);
    end

    // SCLK stops after a full frame.
    send_frame(16'h1234, 16'hABCD);
    check("locked_pre_timeout", 32'(locked), 1);
    fe0  = ferr_seen;
    fall = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_74a);
      if (fall < 0 && !locked) fall = cyc;
    end
    check("timeout_latency", fall - last_rise, 259);
    check("timeout_no_error", ferr_seen - fe0, 0);
    in_chain   = 1'b0;
    exp_locked = 1'b0;

    repeat (2) send_frame(16'($urandom), 16'($urandom));
    // Reset pulse in the middle of a right word.
    send_word(1'b0, 16'($urandom), 16, 32, -1);
    send_word(1'b1, 16'($urandom), 16, 32, 8);
    repeat (2) send_frame(16'($urandom), 16'($urandom));

    repeat (20) @(negedge clk_74a);
    check("pending_samples", exp_q.size(), 0);
    check("frame_error_total", ferr_seen, exp_ferr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 SHALL have parameter CHANNEL_WIDTH, default 16, giving output sample width; legal range 1..16.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, giving the number of clk_74a cycles without an SCLK rising edge before lock is dropped.
REQ-003 SHALL have port clk_74a  input  1  sole clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i2s_sclk  input  1  bit clock, asynchronous to clk_74a, at most clk_74a/8.
REQ-006 SHALL have port i2s_lrck  input  1  word select, asynchronous; 0 = left word, 1 = right word.
REQ-007 SHALL have port i2s_dat  input  1  serial data, asynchronous, MSB first.
REQ-008 SHALL have port audio_l  output  CHANNEL_WIDTH  most recent left sample.
REQ-009 SHALL have port audio_r  output  CHANNEL_WIDTH  most recent right sample.
REQ-010 SHALL have port sample_valid  output  1  one-cycle pulse marking a new left/right pair.
REQ-011 SHALL have port locked  output  1  high while frames are being received correctly.
REQ-012 SHALL have port frame_error  output  1  one-cycle pulse on a short word.

Function
REQ-013 SHALL pass i2s_sclk, i2s_lrck and i2s_dat each through an identical 2-flop synchronizer; an SCLK rise SHALL be detected from synchronized SCLK compared against its previous value.
REQ-014 SHALL sample the synchronized LRCK and DAT only on a detected SCLK rise.
REQ-015 SHALL treat the first SCLK rise whose LRCK differs from the LRCK at the previous rise as the I2S delay bit: DAT ignored, bit counter cleared to 0.
REQ-016 On each later rise with bit counter < 16, SHALL shift DAT into a 16-bit shift register LSB-first-in (MSB arrives first) and increment the counter; counter saturates at 16, and bits 17..32 of a word SHALL be ignored.
REQ-017 On the rise that captures bit 16, SHALL take the word as {shreg[14:0], DAT}; the captured channel value is word[15:16-CHANNEL_WIDTH].
REQ-018 SHALL implement states HUNT, RX_LEFT, RX_RIGHT.
REQ-019 HUNT: on a delay bit with LRCK=0 -> RX_LEFT; all other rises ignored.
REQ-020 RX_LEFT: on the 16th bit, hold the value internally; on a delay bit with LRCK=1 after 16 bits -> RX_RIGHT.
REQ-021 RX_RIGHT: on the 16th bit, load audio_l from the held value, load audio_r from the right word, pulse sample_valid, set locked; on a delay bit with LRCK=0 after 16 bits -> RX_LEFT.
REQ-022 A delay bit in RX_LEFT or RX_RIGHT with bit counter < 16 SHALL pulse frame_error, clear locked, discard the partial word and held left value, and go to HUNT; if its new LRCK is 0 it SHALL also act as the HUNT->RX_LEFT delay bit on the same rise.
REQ-023 audio_l, audio_r and sample_valid SHALL update on the third clk_74a rising edge after the SCLK rising edge at the pin that carries the right-word 16th bit.
REQ-024 audio_l and audio_r SHALL hold their values between sample_valid pulses.
REQ-025 SHALL keep an idle counter of clk_74a cycles since the last SCLK rise, cleared on each rise and saturating at TIMEOUT_CYCLES.
REQ-026 When the idle counter reaches TIMEOUT_CYCLES, SHALL clear locked and enter HUNT without pulsing frame_error.
REQ-027 sample_valid and frame_error SHALL never be high in the same cycle.

Reset
REQ-028 While reset is high, SHALL force state HUNT, bit counter 0, shift register 0, idle counter 0, audio_l = 0, audio_r = 0, sample_valid = 0, locked = 0, frame_error = 0; synchronizer flops SHALL also clear to 0.
REQ-029 Reset asserted mid-word SHALL discard all partial data; the first sample_valid after release SHALL need a complete left word followed by a complete right word.

Verification
REQ-030 Standard 64-SCLK frames at 3.072 MHz, L=16'h1234, R=16'hABCD, CHANNEL_WIDTH=16 -> one sample_valid per frame, audio_l=16'h1234, audio_r=16'hABCD, locked=1 after the first frame.
REQ-031 CHANNEL_WIDTH=15, L=16'hFFFE, R=16'h8001 -> audio_l=15'h7FFF, audio_r=15'h4000.
REQ-032 LRCK toggles after only 10 bits of a left word -> one frame_error pulse, locked=0, no sample_valid for that frame, and correct samples on the next full frame.
REQ-033 SCLK stopped for 300 clk_74a cycles with default TIMEOUT_CYCLES -> locked falls exactly 256 cycles after the last rise, with no frame_error.
REQ-034 Reset asserted for 1 cycle in the middle of a right word -> outputs are 0 and the next sample_valid arrives only after the following full left+right pair.
REQ-035 Streaming starts at a right word, LRCK=1 -> that word is ignored and the first sample_valid comes at the end of the next right word.
